// File: rtl/fp_addsub_unit_pkg.sv
// Shared floating-point constants and state encoding for the add/sub unit
// and the divider that drives it.
package fp_addsub_unit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND
    } fpState_e;

    // Bit position of the exponent MSB for a given precision
    function automatic int fpExpMsb(input int precision);
        return (precision == 64) ? 62 : 30;
    endfunction

    // Bit position of the stored-fraction MSB for a given precision
    function automatic int fpManMsb(input int precision);
        return (precision == 64) ? 51 : 22;
    endfunction

    // Exponent bias for a given precision
    function automatic int fpBias(input int precision);
        return (precision == 64) ? 1023 : 127;
    endfunction

endpackage

// File: rtl/fp_addsub_unit_lzc.sv
// Combinational leading-zero counter used to renormalise the adder sum.
module fp_addsub_unit_lzc #(
    parameter int WIDTH = 28,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count
);

    // Scan upward so the highest set bit has the final say; all-zero gives WIDTH
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_unit.sv
// Multi-cycle IEEE-754 adder/subtractor, round-to-nearest-even, fixed latency,
// one-cycle Valid pulse. Specials finish one cycle after Load.
module fp_addsub_unit
    import fp_addsub_unit_pkg::*;
#(
    parameter int PRECISION = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [PRECISION-1:0] A,
    input  logic [PRECISION-1:0] B,
    input  logic                 Op,
    input  logic                 Load,
    output logic [PRECISION-1:0] Out,
    output logic                 Valid
);

    localparam int E  = fpExpMsb(PRECISION);
    localparam int M  = fpManMsb(PRECISION);
    localparam int EW = E - M;
    localparam int MH = M + 2;
    localparam int FW = M + 5;
    localparam int SW = M + 6;
    localparam int XW = EW + 3;
    localparam int LW = $clog2(SW + 1);

    localparam logic [PRECISION-1:0] ZERO = '0;
    localparam logic [PRECISION-1:0] PINF = {1'b0, {EW{1'b1}}, {(M+1){1'b0}}};
    localparam logic [PRECISION-1:0] NINF = {1'b1, {EW{1'b1}}, {(M+1){1'b0}}};
    localparam logic [PRECISION-1:0] NAN  = {1'b0, {(PRECISION-1){1'b1}}};
    localparam logic [EW-1:0]         MAX_SHIFT = EW'(M + 3);
    localparam logic signed [XW-1:0]  EXP_ONE   = XW'(1);
    localparam logic signed [XW-1:0]  EXP_INF   = XW'((1 << EW) - 1);

    fpState_e state, nextState;

    logic          signA, signB;
    logic [EW-1:0] expA, expB;
    logic [M:0]    fracA, fracB;
    logic          nanA, nanB, infA, infB, zeroA, zeroB;
    logic          isSpecial;
    logic [PRECISION-1:0] specialResult;

    logic          specialFlag;
    logic          capSignA, capSignB;
    logic [EW-1:0] capExpA, capExpB;
    logic [MH-1:0] capMantA, capMantB;

    logic          aFirst, bigSign, smallSign;
    logic [EW-1:0] bigExp, smallExp, shiftAmt;
    logic [MH-1:0] bigMant, smallMant;
    logic [2*FW-1:0] shiftExt;
    logic [FW-1:0] alignedSmall;

    logic          alSign, alSub;
    logic [EW-1:0] alExp;
    logic [FW-1:0] alBig, alSmall;

    logic [SW-1:0] sumComb;
    logic [SW-1:0] adSum;
    logic          adSign, adZero;
    logic signed [XW-1:0] adExp;

    logic [LW-1:0] lzcCount, normShift;
    logic [FW-1:0] normField;
    logic signed [XW-1:0] normExp;

    logic [FW-1:0] nmField;
    logic          nmSign, nmZero;
    logic signed [XW-1:0] nmExp;

    logic [MH-1:0] rndMant;
    logic          roundUp;
    logic [MH:0]   rounded;
    logic [M:0]    rndFrac;
    logic signed [XW-1:0] rndExp;
    logic [PRECISION-1:0] roundResult;

    assign signA = A[PRECISION-1];
    assign signB = B[PRECISION-1] ^ Op;
    assign expA  = A[E:M+1];
    assign expB  = B[E:M+1];
    assign fracA = A[M:0];
    assign fracB = B[M:0];
    assign nanA  = (&expA) && (fracA != '0);
    assign nanB  = (&expB) && (fracB != '0);
    assign infA  = (&expA) && (fracA == '0);
    assign infB  = (&expB) && (fracB == '0);
    assign zeroA = (expA == '0);
    assign zeroB = (expB == '0);

    // Special-operand resolution in priority order; subnormals count as zero
    always_comb begin
        isSpecial     = 1'b1;
        specialResult = ZERO;
        if (nanA || nanB || (infA && infB && (signA != signB))) begin
            specialResult = NAN;
        end else if (infA) begin
            specialResult = signA ? NINF : PINF;
        end else if (infB) begin
            specialResult = signB ? NINF : PINF;
        end else if (zeroA && zeroB) begin
            specialResult = (signA && signB) ? {1'b1, {(PRECISION-1){1'b0}}} : ZERO;
        end else if (zeroA) begin
            specialResult = {signB, B[PRECISION-2:0]};
        end else if (zeroB) begin
            specialResult = {signA, A[PRECISION-2:0]};
        end else begin
            isSpecial = 1'b0;
        end
    end

    // Order operands by magnitude and shift the smaller into a G/R/S field
    always_comb begin
        aFirst    = {capExpA, capMantA} >= {capExpB, capMantB};
        bigSign   = aFirst ? capSignA : capSignB;
        smallSign = aFirst ? capSignB : capSignA;
        bigExp    = aFirst ? capExpA  : capExpB;
        smallExp  = aFirst ? capExpB  : capExpA;
        bigMant   = aFirst ? capMantA : capMantB;
        smallMant = aFirst ? capMantB : capMantA;
        shiftAmt  = bigExp - smallExp;
        shiftExt  = {smallMant, 3'b000, {FW{1'b0}}} >> shiftAmt;
        if (shiftAmt > MAX_SHIFT) begin
            alignedSmall = FW'(1'b1);
        end else begin
            alignedSmall = shiftExt[2*FW-1:FW] | FW'(|shiftExt[FW-1:0]);
        end
    end

    // Magnitude add or subtract; the larger operand always comes first
    always_comb begin
        sumComb = alSub ? ({1'b0, alBig} - {1'b0, alSmall})
                        : ({1'b0, alBig} + {1'b0, alSmall});
    end

    fp_addsub_unit_lzc #(.WIDTH(SW)) lzcInst (
        .value (adSum),
        .count (lzcCount)
    );

    // Renormalise: the carry bit counts as a leading zero, hence the minus one
    always_comb begin
        normShift = lzcCount - LW'(1);
        if (adSum[SW-1]) begin
            normField = {adSum[SW-1:2], adSum[1] | adSum[0]};
            normExp   = adExp + EXP_ONE;
        end else begin
            normField = FW'(adSum << normShift);
            normExp   = adExp - XW'(normShift);
        end
    end

    // Round to nearest even, then clamp to Inf or flush to signed zero
    always_comb begin
        rndMant = nmField[FW-1:3];
        roundUp = nmField[2] && (nmField[1] || nmField[0] || rndMant[0]);
        rounded = {1'b0, rndMant} + {{MH{1'b0}}, roundUp};
        rndFrac = rounded[MH] ? rounded[M+1:1] : rounded[M:0];
        rndExp  = rounded[MH] ? (nmExp + EXP_ONE) : nmExp;
        if (nmZero) begin
            roundResult = ZERO;
        end else if (rndExp >= EXP_INF) begin
            roundResult = nmSign ? NINF : PINF;
        end else if (rndExp < EXP_ONE) begin
            roundResult = {nmSign, {(PRECISION-1){1'b0}}};
        end else begin
            roundResult = {nmSign, rndExp[EW-1:0], rndFrac};
        end
    end

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: Load always restarts; zero sums still walk NORM to keep latency fixed
    always_comb begin
        nextState = state;
        if (Load) begin
            nextState = isSpecial ? ROUND : ALIGN;
        end else begin
            case (state)
                IDLE:    nextState = IDLE;
                ALIGN:   nextState = ADD;
                ADD:     nextState = NORM;
                NORM:    nextState = ROUND;
                ROUND:   nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    // Datapath pipeline registers, result register and completion pulse
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Out         <= '0;
            Valid       <= 1'b0;
            specialFlag <= 1'b0;
            capSignA    <= 1'b0;
            capSignB    <= 1'b0;
            capExpA     <= '0;
            capExpB     <= '0;
            capMantA    <= '0;
            capMantB    <= '0;
            alSign      <= 1'b0;
            alSub       <= 1'b0;
            alExp       <= '0;
            alBig       <= '0;
            alSmall     <= '0;
            adSum       <= '0;
            adSign      <= 1'b0;
            adZero      <= 1'b0;
            adExp       <= '0;
            nmField     <= '0;
            nmSign      <= 1'b0;
            nmZero      <= 1'b0;
            nmExp       <= '0;
        end else begin
            Valid <= 1'b0;
            if (Load) begin
                specialFlag <= isSpecial;
                capSignA    <= signA;
                capSignB    <= signB;
                capExpA     <= expA;
                capExpB     <= expB;
                capMantA    <= {expA != '0, fracA};
                capMantB    <= {expB != '0, fracB};
                if (isSpecial) begin
                    Out <= specialResult;
                end
            end else begin
                case (state)
                    ALIGN: begin
                        alSign  <= bigSign;
                        alSub   <= (bigSign != smallSign);
                        alExp   <= bigExp;
                        alBig   <= {bigMant, 3'b000};
                        alSmall <= alignedSmall;
                    end
                    ADD: begin
                        adSum  <= sumComb;
                        adSign <= alSign;
                        adZero <= (sumComb == '0);
                        adExp  <= {{(XW-EW){1'b0}}, alExp};
                    end
                    NORM: begin
                        nmField <= normField;
                        nmSign  <= adSign;
                        nmZero  <= adZero;
                        nmExp   <= normExp;
                    end
                    ROUND: begin
                        if (!specialFlag) begin
                            Out <= roundResult;
                        end
                        Valid <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_unit.sv
// Scoreboard bench for fp_addsub_unit (single precision): directed vectors push
// expected results and completion cycles; a monitor pops on every Valid.
module tb_fp_addsub_unit;

    typedef struct {
        logic [31:0] expOut;
        int          expCycle;
        string       name;
    } expect_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] A, B, Out;
    logic        Op, Load, Valid;

    expect_t     sbQueue[$];
    expect_t     monEntry;
    int          comparedCount = 0;
    int          mismatchCount = 0;
    int          cycleCount = 0;
    logic        loadSampled = 1'b0;

    fp_addsub_unit #(.PRECISION(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .A     (A),
        .B     (B),
        .Op    (Op),
        .Load  (Load),
        .Out   (Out),
        .Valid (Valid)
    );

    always #5 Clk = ~Clk;

    // Cycle counter and record of whether Load was taken on each edge
    initial begin
        forever begin
            @(posedge Clk);
            cycleCount  = cycleCount + 1;
            loadSampled = Load & ~Reset;
        end
    end

    task automatic checkOutput(input expect_t e);
        comparedCount++;
        if (Out !== e.expOut) begin
            mismatchCount++;
            $display("[TB] FAIL %s result: got %08h, expected %08h", e.name, Out, e.expOut);
        end
        if (e.expCycle >= 0) begin
            comparedCount++;
            if (cycleCount != e.expCycle) begin
                mismatchCount++;
                $display("[TB] FAIL %s latency: Valid at cycle %0d, expected cycle %0d",
                         e.name, cycleCount, e.expCycle);
            end
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        comparedCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    // Monitor: sample between edges, pop the scoreboard on every Valid
    initial begin
        forever begin
            @(negedge Clk);
            if (Reset === 1'b0) begin
                if (loadSampled) begin
                    comparedCount++;
                    if (Valid !== 1'b0) begin
                        mismatchCount++;
                        $display("[TB] FAIL validAfterLoad: Valid=%b in cycle after Load (cycle %0d), expected 0",
                                 Valid, cycleCount);
                    end
                end
                if (Valid === 1'b1) begin
                    if (sbQueue.size() == 0) begin
                        comparedCount++;
                        mismatchCount++;
                        $display("[TB] FAIL unexpectedValid: Valid=1 at cycle %0d with no pending result, expected 0",
                                 cycleCount);
                    end else begin
                        monEntry = sbQueue.pop_front();
                        checkOutput(monEntry);
                    end
                end
            end
        end
    end

    // Drive one Load for a single cycle; latency < 0 means completion time is not checked
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic op,
                                 input logic expectIt, input logic [31:0] expOut,
                                 input int latency, input string name);
        expect_t e;
        @(negedge Clk);
        A    = a;
        B    = b;
        Op   = op;
        Load = 1'b1;
        if (expectIt) begin
            e.expOut   = expOut;
            e.expCycle = (latency < 0) ? -1 : cycleCount + 1 + latency;
            e.name     = name;
            sbQueue.push_back(e);
        end
        @(negedge Clk);
        Load = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        Load  = 1'b0;
        A     = '0;
        B     = '0;
        Op    = 1'b0;
        #1;
        checkValue("resetOut", Out, 32'h0000_0000);
        checkValue("resetValid", {31'b0, Valid}, 32'h0000_0000);
        waitCycles(2);
        Reset = 1'b0;
        waitCycles(1);

        // Normal arithmetic
        applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 1'b1, 32'h40400000, 4, "onePlusTwo");       waitCycles(5);
        applyStimulus(32'h40000000, 32'h3F000000, 1'b1, 1'b1, 32'h3FC00000, 4, "twoMinusHalf");     waitCycles(5);
        applyStimulus(32'h3F800001, 32'h3F800000, 1'b1, 1'b1, 32'h34000000, 4, "cancellation");     waitCycles(5);
        applyStimulus(32'h3F800000, 32'hBF000000, 1'b0, 1'b1, 32'h3F000000, 4, "mixedSigns");       waitCycles(5);
        applyStimulus(32'h3F000000, 32'h40000000, 1'b1, 1'b1, 32'hBFC00000, 4, "swapNegative");     waitCycles(5);
        applyStimulus(32'h40400000, 32'h3F800000, 1'b0, 1'b1, 32'h40800000, 4, "carryOut");         waitCycles(5);
        // Rounding
        applyStimulus(32'h4B800000, 32'h3F800000, 1'b0, 1'b1, 32'h4B800000, 4, "tieToEven");        waitCycles(5);
        applyStimulus(32'h4B800000, 32'h40000000, 1'b0, 1'b1, 32'h4B800001, 4, "lsbAdd");           waitCycles(5);
        applyStimulus(32'h3F800000, 32'h33800000, 1'b0, 1'b1, 32'h3F800000, 4, "guardOnly");        waitCycles(5);
        applyStimulus(32'h3F7FFFFF, 32'h33000000, 1'b0, 1'b1, 32'h3F800000, 4, "roundCarry");       waitCycles(5);
        applyStimulus(32'h3F800000, 32'h00800000, 1'b0, 1'b1, 32'h3F800000, 4, "stickyOnly");       waitCycles(5);
        // Overflow, underflow, exact zero
        applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F800000, 4, "overflow");         waitCycles(5);
        applyStimulus(32'h00800000, 32'h00800001, 1'b1, 1'b1, 32'h80000000, 4, "underflow");        waitCycles(5);
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b1, 1'b1, 32'h00000000, -1, "exactZero");       waitCycles(5);
        // Specials
        applyStimulus(32'h7F800000, 32'h7F800000, 1'b1, 1'b1, 32'h7FFFFFFF, 1, "infMinusInf");      waitCycles(3);
        applyStimulus(32'h7FC00000, 32'h3F800000, 1'b0, 1'b1, 32'h7FFFFFFF, 1, "nanIn");            waitCycles(3);
        applyStimulus(32'hFF800000, 32'h3F800000, 1'b0, 1'b1, 32'hFF800000, 1, "negInf");           waitCycles(3);
        applyStimulus(32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h80000000, 1, "negZeros");         waitCycles(3);
        applyStimulus(32'h80000000, 32'h00000000, 1'b1, 1'b1, 32'h80000000, 1, "negZeroMinusZero"); waitCycles(3);
        applyStimulus(32'h00000000, 32'h3F800000, 1'b1, 1'b1, 32'hBF800000, 1, "zeroMinusOne");     waitCycles(3);
        applyStimulus(32'h40400000, 32'h00000000, 1'b0, 1'b1, 32'h40400000, 1, "plusZero");         waitCycles(3);
        applyStimulus(32'h00000001, 32'h3F800000, 1'b0, 1'b1, 32'h3F800000, 1, "subnormalFlush");   waitCycles(3);

        // Restart: second Load two edges after the first aborts it
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h0, 4, "aborted");
        applyStimulus(32'h40000000, 32'h40000000, 1'b0, 1'b1, 32'h40800000, 4, "restart");
        waitCycles(6);

        // Back-to-back: next Load issued during the previous Valid cycle
        applyStimulus(32'h40000000, 32'h3F800000, 1'b0, 1'b1, 32'h40400000, 4, "backToBack1");
        waitCycles(3);
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 32'h40000000, 4, "backToBack2");
        waitCycles(5);

        // Asynchronous reset in the middle of an operation
        applyStimulus(32'h40000000, 32'h40000000, 1'b0, 1'b0, 32'h0, 4, "resetVictim");
        waitCycles(1);
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        checkValue("midResetOut", Out, 32'h0000_0000);
        checkValue("midResetValid", {31'b0, Valid}, 32'h0000_0000);
        waitCycles(2);
        Reset = 1'b0;
        waitCycles(8);
        applyStimulus(32'h40400000, 32'h3F800000, 1'b0, 1'b1, 32'h40800000, 4, "afterReset");

        // Bounded drain of outstanding expectations
        for (int i = 0; i < 20 && sbQueue.size() != 0; i++) begin
            @(negedge Clk);
        end
        while (sbQueue.size() != 0) begin
            monEntry = sbQueue.pop_front();
            comparedCount++;
            mismatchCount++;
            $display("[TB] FAIL %s missing: no Valid seen, expected result %08h", monEntry.name, monEntry.expOut);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparedCount, mismatchCount);
        $finish;
    end

endmodule
